// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port RAM: registered issue, 3-cycle read return.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module ram_port_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  logic              pick1;
  logic              accept;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;

  logic              st0_vld_q, st0_id_q;
  logic              st1_vld_q, st1_id_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  // last_q = 1 means port 1 was served most recently, so port 0 wins the next contention.
  logic last_q;

  assign pick1 = req1 & (~req0 | ~last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= win;
    end
  end
`endif

  // Grants are forced low while reset is asserted, independent of the requests.
  assign gnt0   = rst_n & req0 & ~pick1;
  assign gnt1   = rst_n & pick1;
  assign accept = gnt0 | gnt1;
  assign win    = gnt1;

  always_comb begin
    sel_we   = we0;
    sel_addr = addr0;
    sel_data = wdata0;
    if (win) begin
      sel_we   = we1;
      sel_addr = addr1;
      sel_data = wdata1;
    end
  end

  // Issue stage: address and data hold when idle, only the write strobe drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      ram_we_q <= accept & sel_we;
      if (accept) begin
        ram_addr_q <= sel_addr;
        ram_data_q <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0_vld_q <= 1'b0;
      st0_id_q  <= 1'b0;
      st1_vld_q <= 1'b0;
      st1_id_q  <= 1'b0;
    end else begin
      st0_vld_q <= accept & ~sel_we;
      st0_id_q  <= win;
      st1_vld_q <= st0_vld_q;
      st1_id_q  <= st0_id_q;
    end
  end

  // Stage 1 lines up with ram_q, so capture it for the owning port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= st1_vld_q & ~st1_id_q;
      rvalid1_q <= st1_vld_q & st1_id_q;
      if (st1_vld_q && !st1_id_q) begin
        rdata0_q <= ram_q;
      end
      if (st1_vld_q && st1_id_q) begin
        rdata1_q <= ram_q;
      end
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] ram_data, ram_q;
  logic [5:0] ram_addr;
  logic       ram_we;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .DATA_W(8),
    .ADDR_W(6)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .we0     (we0),
    .addr0   (addr0),
    .wdata0  (wdata0),
    .req1    (req1),
    .we1     (we1),
    .addr1   (addr1),
    .wdata1  (wdata1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .ram_data(ram_data),
    .ram_addr(ram_addr),
    .ram_we  (ram_we),
    .ram_q   (ram_q)
  );

  // Single-port RAM: synchronous write, registered read address.
  logic [7:0] ram_mem [64] = '{default: 8'h00};
  logic [5:0] ram_raddr = 6'd0;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_raddr <= ram_addr;
  end
  assign ram_q = ram_mem[ram_raddr];

  typedef struct {
    int         cyc;
    bit         port;
    logic [7:0] data;
  } rsp_t;

  rsp_t       rq[$];
  logic [7:0] mem_m [64] = '{default: 8'h00};
  bit         last_m;
  int         cyc;
  int         last_grant;
  int         n_chk, n_bad;
  logic       exp_we, nx_we;
  logic [5:0] exp_addr, nx_addr;
  logic [7:0] exp_data, nx_data, exp_rd0, exp_rd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    last_m   = 1'b1;
    exp_we   = 1'b0;
    nx_we    = 1'b0;
    exp_addr = '0;
    nx_addr  = '0;
    exp_data = '0;
    nx_data  = '0;
    exp_rd0  = '0;
    exp_rd1  = '0;
  endtask

  // Called at posedge+1 with inputs applied; checks this cycle and advances one clock.
  task automatic step();
    int         eg;
    bit         ev0, ev1, p, w;
    logic [5:0] a;
    logic [7:0] d;
    @(negedge clk);
    eg = -1;
    if (req0 && req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      eg = 0;
`else
      eg = last_m ? 0 : 1;
`endif
    end else if (req0) eg = 0;
    else if (req1) eg = 1;
    check("gnt0", 32'(gnt0), 32'(eg == 0));
    check("gnt1", 32'(gnt1), 32'(eg == 1));
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      if (rq[0].port) begin ev1 = 1'b1; exp_rd1 = rq[0].data; end
      else            begin ev0 = 1'b1; exp_rd0 = rq[0].data; end
      void'(rq.pop_front());
    end
    check("rvalid0", 32'(rvalid0), 32'(ev0));
    check("rvalid1", 32'(rvalid1), 32'(ev1));
    check("rdata0", 32'(rdata0), 32'(exp_rd0));
    check("rdata1", 32'(rdata1), 32'(exp_rd1));
    check("ram_we", 32'(ram_we), 32'(exp_we));
    check("ram_addr", 32'(ram_addr), 32'(exp_addr));
    check("ram_data", 32'(ram_data), 32'(exp_data));
    last_grant = eg;
    nx_we = 1'b0;
    if (eg >= 0) begin
      p = (eg == 1);
      w = p ? we1 : we0;
      a = p ? addr1 : addr0;
      d = p ? wdata1 : wdata0;
      nx_we   = w;
      nx_addr = a;
      nx_data = d;
      // Accesses complete in accept order, so a read sees every earlier accepted write.
      if (w) mem_m[a] = d;
      else rq.push_back('{cyc: cyc + 3, port: p, data: mem_m[a]});
      last_m = p;
    end
    @(posedge clk);
    cyc++;
    exp_we   = nx_we;
    exp_addr = nx_addr;
    exp_data = nx_data;
    #1;
  endtask

  task automatic drv(input bit r0, input bit w0, input logic [5:0] a0, input logic [7:0] d0,
                     input bit r1, input bit w1, input logic [5:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         p0, p1;
    logic       pw0, pw1;
    logic [5:0] pa0, pa1;
    logic [7:0] pd0, pd1;
    n_chk = 0;
    n_bad = 0;
    cyc   = 0;
    model_reset();
    rst_n = 1'b0;
    req0 = 1; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 1; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_outs", {13'd0, ram_we, ram_addr, ram_data, rvalid0, rvalid1, 2'd0}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Port 0 writes then reads back.
    drv(1, 1, 6'h00, 8'hAA, 0, 0, 6'h00, 8'h00);
    drv(1, 1, 6'h01, 8'hBB, 0, 0, 6'h00, 8'h00);
    drv(1, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00);
    idle(4);

    // Continuous read contention alternates grants.
    for (int i = 0; i < 6; i++) drv(1, 0, 6'h00, 8'h00, 1, 0, 6'h01, 8'h00);
    idle(4);

    // Read-after-write across ports.
    drv(0, 0, 6'h00, 8'h00, 1, 1, 6'h02, 8'hCC);
    drv(1, 0, 6'h02, 8'h00, 0, 0, 6'h00, 8'h00);
    idle(4);

    // Top address.
    drv(1, 1, 6'h3F, 8'hDD, 0, 0, 6'h00, 8'h00);
    drv(0, 0, 6'h00, 8'h00, 1, 0, 6'h3F, 8'h00);
    idle(4);

    // Reset with a read in flight.
    drv(1, 0, 6'h01, 8'h00, 0, 0, 6'h00, 8'h00);
    req0 = 1; we0 = 0; req1 = 1; we1 = 0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    check("mid_rst_outs", {13'd0, ram_we, ram_addr, ram_data, rvalid0, rvalid1, 2'd0}, 32'd0);
    check("mid_rst_rdata", {16'd0, rdata0, rdata1}, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    cyc += 2;
    #1;
    rst_n = 1'b1;
    drv(1, 0, 6'h00, 8'h00, 1, 0, 6'h01, 8'h00);
    idle(5);

    // Random traffic; requests are held until granted.
    p0 = 0; p1 = 0;
    pw0 = 0; pw1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0 = 1;
        pw0 = 1'($urandom_range(0, 1));
        pa0 = ($urandom_range(0, 15) == 0) ? 6'h3F : 6'($urandom_range(0, 7));
        pd0 = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1;
        pw1 = 1'($urandom_range(0, 1));
        pa1 = ($urandom_range(0, 15) == 0) ? 6'h3F : 6'($urandom_range(0, 7));
        pd1 = 8'($urandom);
      end
      drv(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1);
      if (last_grant == 0) p0 = 0;
      if (last_grant == 1) p1 = 0;
    end
    idle(5);
    check("drain", 32'(rq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester round-robin arbiter that shares one `single_port_ram` (8-bit data, 6-bit address, synchronous write, registered read address) between two masters. It accepts at most one access per cycle through a req/gnt handshake, drives the RAM port from registers, and routes read data back to the winning requester with a fixed 3-cycle latency. It sits directly in front of the RAM instance; requesters never touch the RAM ports.

## Interface
- `DATA_W`, 8, data width; matches RAM `data`/`q`.
- `ADDR_W`, 6, address width; matches RAM `addr`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request, held until granted.
- `we0` / `we1`  in  1  1 = write, 0 = read; stable while `reqN` high.
- `addr0` / `addr1`  in  ADDR_W  access address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `gnt0` / `gnt1`  out  1  combinational accept; transfer occurs on the edge where `reqN && gntN`.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse, read data valid.
- `rdata0` / `rdata1`  out  DATA_W  read data, registered, held until next `rvalidN`.
- `ram_data`  out  DATA_W  to RAM `data`.
- `ram_addr`  out  ADDR_W  to RAM `addr`.
- `ram_we`  out  1  to RAM `we`.
- `ram_q`  in  DATA_W  from RAM `q`.

## Operation
- Arbitration (combinational): only one requester -> that one granted. Both -> the one not granted most recently. Neither -> no grant. At most one of `gnt0`/`gnt1` high in any cycle.
- `last` register (1 bit) records the last granted port; updates only on an accepted transfer. Reset value `last = 1`, so port 0 wins the first contention.
- Issue stage: on accept, register `ram_addr <= addrN`, `ram_data <= wdataN`, `ram_we <= weN`. No accept -> `ram_we <= 0`; `ram_addr`/`ram_data` hold.
- Tracking pipeline: 2-stage shift register of {valid, port id}; stage 0 loaded with {accepted && !we, winner}, stage 1 <= stage 0.
- Return: when stage 1 valid, `rdataID <= ram_q`, `rvalidID <= 1` for one cycle; other port's `rdata` unchanged.
- Writes produce no response; complete when RAM samples `ram_we`.
- Back-to-back accepts permitted every cycle; read-after-write to same address from either port returns new data (write committed before read is sampled, RAM ordering).
- Held request with no grant: arbiter sees stable req; loser is granted next cycle when the winner drops or alternates (round-robin guarantees service within 2 cycles under contention).

## Timing
- Cycle N: `reqN && gntN` -> accepted at end of N.
- Cycle N+1: RAM ports driven; RAM samples at end of N+1.
- Cycle N+2: `ram_q` valid.
- Cycle N+3: `rvalidN = 1`, `rdataN` valid. Read latency 3 cycles from accept edge; throughput 1 access/cycle.
- Reset (asynchronous assert, any time): `gnt0 = gnt1 = 0` while `rst_n` low; `ram_we = 0`, `ram_addr = 0`, `ram_data = 0`, `rvalid0 = rvalid1 = 0`, `rdata0 = rdata1 = 0`, pipeline cleared, `last = 1`. In-flight reads are dropped: no `rvalid` after release for accesses accepted before reset. Writes already registered but not yet sampled by RAM are aborted.
- Release: first accept possible in first cycle with `rst_n` high.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`: defined -> fixed priority, port 0 always wins contention, `last` unused (port 1 may starve). Undefined (default) -> round-robin as above. All other behaviour and latency identical.

## Test plan
- Port 0 writes 0xAA@0x00, 0xBB@0x01 back-to-back, then reads 0x00 -> `gnt0` each cycle, `rvalid0` 3 cycles after read accept with `rdata0 = 0xAA`; `rvalid1` never asserts.
- Both ports request reads every cycle (port 0 @0x00, port 1 @0x01) after reset -> grants alternate 0,1,0,1; `rdata0 = 0xAA`, `rdata1 = 0xBB`, `rvalid` pulses alternate.
- Port 1 writes 0xCC@0x02 in cycle N, port 0 reads 0x02 in N+1 -> `rdata0 = 0xCC` at N+4.
- Assert `rst_n` low one cycle after a read accept -> no `rvalid` after release, all outputs 0 during reset, first contention after release granted to port 0.
- Address 0x3F write 0xDD, read back -> `ram_addr = 0x3F` in issue cycle, `rdata = 0xDD`; with `RAM_ARB_FIXED_PRIO_EN`, continuous contention -> `gnt1` never asserts.
